// File: rtl/lcd_arbiter_if.sv
// Bundle of the two client command words, the grant/ack handshake and the
// single word path toward the LCD instruction engine.
interface lcd_arbiter_if #(
  parameter int LCD_DATA_BIT_WIDTH              = 8,
  parameter int LCD_ROW_COUNT_BIT_WIDTH         = 6,
  parameter int LCD_ADDR_Y_COUNT_BIT_WIDTH      = 6,
  parameter int LCD_ADDR_X_COUNT_BIT_WIDTH      = 3,
  parameter int LCD_DATA_ACTION_COUNT_BIT_WIDTH = 2
);
  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic       timeout_err;

  logic [LCD_DATA_BIT_WIDTH-1:0]              c0_data, c1_data;
  logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]         c0_start_line, c1_start_line;
  logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0]      c0_addr_y, c1_addr_y;
  logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0]      c0_addr_x, c1_addr_x;
  logic [LCD_DATA_ACTION_COUNT_BIT_WIDTH-1:0] c0_action, c1_action;

  logic                                       instr_busy;
  logic                                       data_busy;
  logic [LCD_DATA_BIT_WIDTH-1:0]              data;
  logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]         start_line;
  logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0]      addr_y;
  logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0]      addr_x;
  logic [LCD_DATA_ACTION_COUNT_BIT_WIDTH-1:0] data_action;

  modport slave (
    input  req, lock,
    input  c0_data, c1_data, c0_start_line, c1_start_line,
    input  c0_addr_y, c1_addr_y, c0_addr_x, c1_addr_x, c0_action, c1_action,
    input  instr_busy,
    output gnt, ack, timeout_err,
    output data_busy, data, start_line, addr_y, addr_x, data_action
  );

  modport master (
    output req, lock,
    output c0_data, c1_data, c0_start_line, c1_start_line,
    output c0_addr_y, c1_addr_y, c0_addr_x, c1_addr_x, c0_action, c1_action,
    output instr_busy,
    input  gnt, ack, timeout_err,
    input  data_busy, data, start_line, addr_y, addr_x, data_action
  );
endinterface

// File: rtl/lcd_arbiter.sv
// Two-client arbiter in front of the LCD instruction engine: round-robin ties,
// locked bursts, accept timeout, one registered command word at a time.
module lcd_arbiter #(
  parameter int ACCEPT_TIMEOUT                  = 4095,
  parameter int LCD_DATA_BIT_WIDTH              = 8,
  parameter int LCD_ROW_COUNT_BIT_WIDTH         = 6,
  parameter int LCD_ADDR_Y_COUNT_BIT_WIDTH      = 6,
  parameter int LCD_ADDR_X_COUNT_BIT_WIDTH      = 3,
  parameter int LCD_DATA_ACTION_COUNT_BIT_WIDTH = 2,
  parameter logic [LCD_DATA_ACTION_COUNT_BIT_WIDTH-1:0] LCD_DATA_ACTION_WRITE_DATA = 1
) (
  input logic         clk_ctrl,
  input logic         reset,
  lcd_arbiter_if.slave bus
);
  localparam logic [1:0]  IDLE          = 2'd0;
  localparam logic [1:0]  WAIT_ACCEPT   = 2'd1;
  localparam logic [1:0]  WAIT_DONE     = 2'd2;
  localparam logic [11:0] TIMEOUT_LIMIT = 12'(ACCEPT_TIMEOUT);

  logic [1:0]  state_reg;
  logic [1:0]  gnt_reg, ack_reg;
  logic        timeout_reg;
  logic        last_reg, winner_reg;
  logic        owner_valid_reg, owner_reg;
  logic [11:0] count_reg;
  logic        data_busy_reg;

  logic [LCD_DATA_BIT_WIDTH-1:0]              data_reg;
  logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]         start_line_reg;
  logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0]      addr_y_reg;
  logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0]      addr_x_reg;
  logic [LCD_DATA_ACTION_COUNT_BIT_WIDTH-1:0] action_reg;

  logic [LCD_DATA_BIT_WIDTH-1:0]              cl_data       [2];
  logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]         cl_start_line [2];
  logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0]      cl_addr_y     [2];
  logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0]      cl_addr_x     [2];
  logic [LCD_DATA_ACTION_COUNT_BIT_WIDTH-1:0] cl_action     [2];

  logic       owner_locked;
  logic       win_valid, win_idx;
  logic [1:0] win_onehot;

  assign cl_data[0]       = bus.c0_data;
  assign cl_data[1]       = bus.c1_data;
  assign cl_start_line[0] = bus.c0_start_line;
  assign cl_start_line[1] = bus.c1_start_line;
  assign cl_addr_y[0]     = bus.c0_addr_y;
  assign cl_addr_y[1]     = bus.c1_addr_y;
  assign cl_addr_x[0]     = bus.c0_addr_x;
  assign cl_addr_x[1]     = bus.c1_addr_x;
  assign cl_action[0]     = bus.c0_action;
  assign cl_action[1]     = bus.c1_action;

  assign owner_locked = owner_valid_reg && bus.lock[owner_reg];

  // A locked owner blocks the other client even while its own req is low.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 1'b0;
    if (owner_locked) begin
      win_valid = bus.req[owner_reg];
      win_idx   = owner_reg;
    end else begin
      unique case (bus.req)
        2'b01:   begin win_valid = 1'b1; win_idx = 1'b0;      end
        2'b10:   begin win_valid = 1'b1; win_idx = 1'b1;      end
        2'b11:   begin win_valid = 1'b1; win_idx = ~last_reg; end
        default: begin win_valid = 1'b0; win_idx = 1'b0;      end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
    assign win_onehot[gi] = win_valid && (win_idx == 1'(gi));
  end

  always_ff @(posedge clk_ctrl) begin
    if (reset) begin
      state_reg       <= IDLE;
      gnt_reg         <= 2'b00;
      ack_reg         <= 2'b00;
      timeout_reg     <= 1'b0;
      last_reg        <= 1'b1;
      winner_reg      <= 1'b0;
      owner_valid_reg <= 1'b0;
      owner_reg       <= 1'b0;
      count_reg       <= '0;
      data_busy_reg   <= 1'b1;
      data_reg        <= '0;
      start_line_reg  <= '0;
      addr_y_reg      <= '0;
      addr_x_reg      <= '0;
      action_reg      <= LCD_DATA_ACTION_WRITE_DATA;
    end else begin
      ack_reg     <= 2'b00;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!bus.instr_busy) begin
            if (!owner_locked) owner_valid_reg <= 1'b0;
            if (win_valid) begin
              data_reg       <= cl_data[win_idx];
              start_line_reg <= cl_start_line[win_idx];
              addr_y_reg     <= cl_addr_y[win_idx];
              addr_x_reg     <= cl_addr_x[win_idx];
              action_reg     <= cl_action[win_idx];
              gnt_reg        <= win_onehot;
              last_reg       <= win_idx;
              winner_reg     <= win_idx;
              data_busy_reg  <= 1'b0;
              count_reg      <= '0;
              state_reg      <= WAIT_ACCEPT;
            end
          end
        end
        WAIT_ACCEPT: begin
          // Accept beats a coincident timeout.
          if (bus.instr_busy) begin
            data_busy_reg   <= 1'b1;
            ack_reg         <= gnt_reg;
            owner_valid_reg <= bus.lock[winner_reg];
            owner_reg       <= winner_reg;
            state_reg       <= WAIT_DONE;
          end else if (count_reg == TIMEOUT_LIMIT) begin
            data_busy_reg   <= 1'b1;
            timeout_reg     <= 1'b1;
            gnt_reg         <= 2'b00;
            owner_valid_reg <= 1'b0;
            state_reg       <= IDLE;
          end else begin
            count_reg <= count_reg + 12'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.instr_busy) begin
            gnt_reg   <= 2'b00;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.ack         = ack_reg;
  assign bus.timeout_err = timeout_reg;
  assign bus.data_busy   = data_busy_reg;
  assign bus.data        = data_reg;
  assign bus.start_line  = start_line_reg;
  assign bus.addr_y      = addr_y_reg;
  assign bus.addr_x      = addr_x_reg;
  assign bus.data_action = action_reg;
endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter: directed words pushed as expectations,
// a negedge monitor pops one per ack/timeout_err pulse.
module tb_lcd_arbiter;
  localparam logic [1:0] WRITE_DATA = 2'd1;

  typedef struct {
    bit         is_to;
    bit         cl;
    logic [7:0] data;
    logic [5:0] sl;
    logic [5:0] ay;
    logic [2:0] ax;
    logic [1:0] act;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eng_en = 1'b0, eng_busy = 1'b0, force_busy = 1'b0;

  always #5 clk = ~clk;

  lcd_arbiter_if #(
    .LCD_DATA_BIT_WIDTH(8), .LCD_ROW_COUNT_BIT_WIDTH(6),
    .LCD_ADDR_Y_COUNT_BIT_WIDTH(6), .LCD_ADDR_X_COUNT_BIT_WIDTH(3),
    .LCD_DATA_ACTION_COUNT_BIT_WIDTH(2)
  ) bus ();

  assign bus.instr_busy = eng_busy | force_busy;

  lcd_arbiter #(
    .ACCEPT_TIMEOUT(8),
    .LCD_DATA_BIT_WIDTH(8), .LCD_ROW_COUNT_BIT_WIDTH(6),
    .LCD_ADDR_Y_COUNT_BIT_WIDTH(6), .LCD_ADDR_X_COUNT_BIT_WIDTH(3),
    .LCD_DATA_ACTION_COUNT_BIT_WIDTH(2), .LCD_DATA_ACTION_WRITE_DATA(WRITE_DATA)
  ) dut (
    .clk_ctrl(clk),
    .reset(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_c0(input logic [7:0] d, input logic [5:0] sl, input logic [5:0] ay,
                        input logic [2:0] ax, input logic [1:0] act);
    bus.c0_data = d; bus.c0_start_line = sl; bus.c0_addr_y = ay;
    bus.c0_addr_x = ax; bus.c0_action = act;
  endtask

  task automatic set_c1(input logic [7:0] d, input logic [5:0] sl, input logic [5:0] ay,
                        input logic [2:0] ax, input logic [1:0] act);
    bus.c1_data = d; bus.c1_start_line = sl; bus.c1_addr_y = ay;
    bus.c1_addr_x = ax; bus.c1_action = act;
  endtask

  task automatic push_word(input bit cl, input logic [7:0] d, input logic [5:0] sl,
                           input logic [5:0] ay, input logic [2:0] ax, input logic [1:0] act);
    exp_t e;
    e.is_to = 1'b0; e.cl = cl; e.data = d; e.sl = sl; e.ay = ay; e.ax = ax; e.act = act;
    sb.push_back(e);
  endtask

  task automatic push_timeout();
    exp_t e;
    e.is_to = 1'b1; e.cl = 1'b0; e.data = '0; e.sl = '0; e.ay = '0; e.ax = '0; e.act = '0;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int c, input string name, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ack[c]) break;
      if (cyc >= 60) begin
        n_total++;
        $display("FAIL %s: ack[%0d] not seen, expected within 60 cycles", name, c);
        break;
      end
    end
  endtask

  task automatic wait_gnt(input logic [1:0] g, input string name);
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (bus.gnt == g) break;
      if (cyc >= 60) begin
        n_total++;
        $display("FAIL %s: gnt=%b, expected %b within 60 cycles", name, bus.gnt, g);
        break;
      end
    end
  endtask

  // Engine model: takes a pending word one cycle after data_busy falls, busy for one cycle.
  initial forever begin
    @(posedge clk); #1;
    if (eng_en && !bus.data_busy && !eng_busy) begin
      eng_busy = 1'b1;
      @(posedge clk); #1;
      eng_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && (bus.ack != 2'b00 || bus.timeout_err)) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: ack=%b timeout_err=%b, expected none", bus.ack, bus.timeout_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_to) begin
          $display("txn timeout_err gnt=%b", bus.gnt);
          check("to_err", 32'(bus.timeout_err), 32'd1);
          check("to_no_ack", 32'(bus.ack), 32'd0);
        end else begin
          $display("txn ack=%b data=%h sl=%0d ay=%0d ax=%0d act=%0d",
                   bus.ack, bus.data, bus.start_line, bus.addr_y, bus.addr_x, bus.data_action);
          check("ack_client", 32'(bus.ack), 32'({e.cl, ~e.cl}));
          check("ack_gnt", 32'(bus.gnt), 32'({e.cl, ~e.cl}));
          check("ack_no_to", 32'(bus.timeout_err), 32'd0);
          check("word_data", 32'(bus.data), 32'(e.data));
          check("word_start_line", 32'(bus.start_line), 32'(e.sl));
          check("word_addr_y", 32'(bus.addr_y), 32'(e.ay));
          check("word_addr_x", 32'(bus.addr_x), 32'(e.ax));
          check("word_action", 32'(bus.data_action), 32'(e.act));
        end
      end
    end
  end

  initial begin
    int cyc;
    bus.req = 2'b00; bus.lock = 2'b00;
    set_c0(8'h00, 6'd0, 6'd0, 3'd0, 2'd0);
    set_c1(8'h00, 6'd0, 6'd0, 3'd0, 2'd0);

    // Reset values.
    tick(2);
    check("rst_data_busy", 32'(bus.data_busy), 32'd1);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_to", 32'(bus.timeout_err), 32'd0);
    check("rst_action", 32'(bus.data_action), 32'(WRITE_DATA));
    check("rst_data", 32'(bus.data), 32'd0);
    eng_en = 1'b1;

    // Tie round robin from reset: 0,1,0,1.
    set_c0(8'h11, 6'd1, 6'd2, 3'd1, 2'd2);
    set_c1(8'h21, 6'd5, 6'd6, 3'd4, 2'd3);
    push_word(1'b0, 8'h11, 6'd1, 6'd2, 3'd1, 2'd2);
    push_word(1'b1, 8'h21, 6'd5, 6'd6, 3'd4, 2'd3);
    push_word(1'b0, 8'h12, 6'd1, 6'd2, 3'd1, 2'd2);
    push_word(1'b1, 8'h22, 6'd5, 6'd6, 3'd4, 2'd3);
    rst = 1'b0;
    bus.req = 2'b11;
    wait_ack(0, "rr_w0", cyc);
    bus.c0_data = 8'h12;
    wait_ack(1, "rr_w1", cyc);
    bus.c1_data = 8'h22;
    wait_ack(0, "rr_w2", cyc);
    wait_ack(1, "rr_w3", cyc);
    bus.req = 2'b00;
    tick(2);

    // Busy at request, then single client word.
    force_busy = 1'b1;
    set_c0(8'hA5, 6'd9, 6'd17, 3'd3, 2'd2);
    bus.req = 2'b01;
    tick(3);
    check("busy_no_gnt", 32'(bus.gnt), 32'd0);
    check("busy_data_busy", 32'(bus.data_busy), 32'd1);
    push_word(1'b0, 8'hA5, 6'd9, 6'd17, 3'd3, 2'd2);
    force_busy = 1'b0;
    wait_ack(0, "single_ack", cyc);
    check("single_latency", 32'(cyc), 32'd2);
    check("ack_data_busy", 32'(bus.data_busy), 32'd1);
    bus.req = 2'b00;
    tick(1);
    check("gnt_release", 32'(bus.gnt), 32'd0);
    tick(2);

    // Locked burst: three consecutive client 1 words, client 0 waits for lock drop.
    set_c0(8'h30, 6'd3, 6'd4, 3'd5, 2'd2);
    set_c1(8'h41, 6'd7, 6'd8, 3'd6, 2'd3);
    push_word(1'b1, 8'h41, 6'd7, 6'd8, 3'd6, 2'd3);
    push_word(1'b1, 8'h42, 6'd7, 6'd8, 3'd6, 2'd3);
    push_word(1'b1, 8'h43, 6'd7, 6'd8, 3'd6, 2'd3);
    push_word(1'b0, 8'h30, 6'd3, 6'd4, 3'd5, 2'd2);
    bus.lock = 2'b10;
    bus.req = 2'b11;
    wait_ack(1, "lock_w0", cyc);
    bus.c1_data = 8'h42;
    wait_ack(1, "lock_w1", cyc);
    bus.c1_data = 8'h43;
    wait_ack(1, "lock_w2", cyc);
    bus.req = 2'b01;
    tick(6);
    check("lock_hold_gnt", 32'(bus.gnt), 32'd0);
    bus.lock = 2'b00;
    wait_ack(0, "lock_release", cyc);
    check("lock_release_latency", 32'(cyc), 32'd2);
    bus.req = 2'b00;
    tick(3);

    // Accept timeout after 9 cycles, then the next request is served.
    eng_en = 1'b0;
    set_c0(8'h5A, 6'd2, 6'd3, 3'd2, 2'd2);
    push_timeout();
    bus.req = 2'b01;
    wait_gnt(2'b01, "to_grant");
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (bus.timeout_err || cyc >= 30) break;
    end
    check("timeout_cycles", 32'(cyc), 32'd9);
    bus.req = 2'b00;
    check("to_data_busy", 32'(bus.data_busy), 32'd1);
    check("to_gnt", 32'(bus.gnt), 32'd0);
    eng_en = 1'b1;
    set_c1(8'h66, 6'd11, 6'd12, 3'd7, 2'd3);
    push_word(1'b1, 8'h66, 6'd11, 6'd12, 3'd7, 2'd3);
    bus.req = 2'b10;
    wait_ack(1, "after_to_ack", cyc);
    bus.req = 2'b00;
    tick(3);

    // Reset during WAIT_ACCEPT abandons the word without ack.
    eng_en = 1'b0;
    set_c0(8'h77, 6'd1, 6'd1, 3'd1, 2'd2);
    bus.req = 2'b01;
    wait_gnt(2'b01, "rst_mid_grant");
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst_mid_data_busy", 32'(bus.data_busy), 32'd1);
    check("rst_mid_gnt", 32'(bus.gnt), 32'd0);
    check("rst_mid_action", 32'(bus.data_action), 32'(WRITE_DATA));
    check("rst_mid_data", 32'(bus.data), 32'd0);
    tick(1);
    rst = 1'b0;
    bus.req = 2'b00;
    eng_en = 1'b1;
    tick(10);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
